// File: rtl/sel_pkg.sv
// Shared types and helpers for the one-hot AND-OR selector pipeline.
package sel_pkg;

    // Widest select vector that is_onehot can examine.
    // Callers zero-extend narrower vectors.
    localparam int MAX_SOURCES = 64;

    // Skid buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sel_state_e;

    // True when exactly one bit of vec is set (popcount == 1).
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [MAX_SOURCES-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_SOURCES'(1))) == '0);
    endfunction

endpackage

// File: rtl/sel_andor_core.sv
// Purely combinational AND-OR selector.
// It masks each operand with its select bit and ORs all of the masked operands.
// There is no priority: a multi-hot select merges the chosen operands.
module sel_andor_core
    import sel_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SOURCES = 4
) (
    input  logic [SOURCES*WIDTH-1:0] src,
    input  logic [SOURCES-1:0]       sel,
    output logic [WIDTH-1:0]         result,
    output logic                     err
);

    logic [WIDTH-1:0]       masked [SOURCES];
    logic [MAX_SOURCES-1:0] sel_ext;

    // Gate each operand with its own select bit.
    for (genvar gi = 0; gi < SOURCES; gi++) begin : g_mask
        assign masked[gi] = src[gi*WIDTH +: WIDTH] & {WIDTH{sel[gi]}};
    end

    // OR-reduce the masked operands into the result.
    always_comb begin
        result = '0;
        for (int i = 0; i < SOURCES; i++) begin
            result = result | masked[i];
        end
    end

    // Zero-extend the select so the shared one-hot helper can examine it.
    always_comb begin
        sel_ext = '0;
        sel_ext[SOURCES-1:0] = sel;
    end

    assign err = !is_onehot(sel_ext);

endmodule

// File: rtl/sel_onehot_pipe.sv
// One-hot AND-OR selector with a registered, flow-controlled output.
// Only {result, err} is buffered.
// M drives the outputs and S is the skid slot used while the consumer stalls.
module sel_onehot_pipe
    import sel_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SOURCES = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SOURCES*WIDTH-1:0] src,
    input  logic [SOURCES-1:0]       sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     out_err,
    output logic [CNT_W-1:0]         err_count
);

    logic [WIDTH-1:0] core_result;
    logic             core_err;

    sel_andor_core #(
        .WIDTH   (WIDTH),
        .SOURCES (SOURCES)
    ) u_core (
        .src    (src),
        .sel    (sel),
        .result (core_result),
        .err    (core_err)
    );

    sel_state_e       state_q, state_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_err_q, m_err_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             s_err_q, s_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready_q;
    assign deliver = out_valid_q && out_ready;

    // Next-state logic for the skid FSM, the M/S slots and the error counter.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_err_d  = m_err_q;
        s_data_d = s_data_q;
        s_err_d  = s_err_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_data_d = core_result;
                    m_err_d  = core_err;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    m_data_d = core_result;
                    m_err_d  = core_err;
                end else if (accept) begin
                    s_data_d = core_result;
                    s_err_d  = core_err;
                    state_d  = FULL;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    m_data_d = s_data_q;
                    m_err_d  = s_err_q;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Handshake flags are registered copies of the next occupancy.
        // This keeps in_ready free of any combinational path from out_ready.
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);

        err_cnt_d = err_cnt_q;
        if (accept && core_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards all buffered beats and the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            m_data_q    <= '0;
            m_err_q     <= 1'b0;
            s_data_q    <= '0;
            s_err_q     <= 1'b0;
            err_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_err_q     <= m_err_d;
            s_data_q    <= s_data_d;
            s_err_q     <= s_err_d;
            err_cnt_q   <= err_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = m_data_q;
    assign out_err   = m_err_q;
    assign err_count = err_cnt_q;

endmodule
